// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches words from
// instruction memory over a req/ack handshake and presents them to decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | one idle cycle after reset release, no request issued
// FETCH | request outstanding at pcReg, waiting for imemAck
// VALID | instruction register live, waiting for decode to consume it
// HALT  | misaligned redirect seen, everything frozen until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    output logic        misaligned,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pcReg;

    // The request address is the PC register itself, so it cannot move
    // while a request is outstanding.
    assign imemAddr = pcReg;
    assign op       = instr[6:0];

    // Fetch sequencer; imemReq and instrValid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pcReg      <= RESET_PC;
            instr      <= NOP_INSTR;
            pc         <= RESET_PC;
            pcPlus4    <= RESET_PC + 32'd4;
            instrValid <= 1'b0;
            misaligned <= 1'b0;
            fetchCount <= 32'd0;
            imemReq    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
                FETCH: begin
                    if (imemAck) begin
                        instr      <= imemRdata;
                        pc         <= pcReg;
                        pcPlus4    <= pcReg + 32'd4;
                        imemReq    <= 1'b0;
                        instrValid <= 1'b1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        fetchCount <= fetchCount + 32'd1;
                        instrValid <= 1'b0;
                        if (pcSrc && (pcTarget[1:0] != 2'b00)) begin
                            // pcReg keeps the last good address for debug.
                            misaligned <= 1'b1;
                            state      <= HALT;
                        end else begin
                            pcReg   <= pcSrc ? pcTarget : pcReg + 32'd4;
                            imemReq <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level reference model
// and a few hand-computed checks of the documented scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b1;
    logic        pcSrc = 1'b0;
    logic [31:0] pcTarget = 32'd0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemRdata = 32'd0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        misaligned;
    logic [31:0] fetchCount;

    int total = 0;
    int bad = 0;
    bit chkEn = 1'b0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pcSrc(pcSrc),
        .pcTarget(pcTarget), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemRdata(imemRdata), .instr(instr), .op(op),
        .pc(pc), .pcPlus4(pcPlus4), .instrValid(instrValid),
        .misaligned(misaligned), .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    // Reference model: what the stage is doing, expressed as flags
    // ("just left reset", "waiting for memory", "holding a word", "dead").
    bit          mFresh, mWaiting, mHolding, mDead, mMis;
    logic [31:0] mNext, mInstr, mPc, mCount;

    task automatic resetModel();
        mFresh = 1; mWaiting = 0; mHolding = 0; mDead = 0; mMis = 0;
        mNext = 32'd0; mInstr = 32'h0000_0013; mPc = 32'd0; mCount = 32'd0;
    endtask

    initial resetModel();
    always @(negedge rst_n) resetModel();

    always @(posedge clk) begin
        if (!rst_n) begin
            resetModel();
        end else if (mDead) begin
            // frozen
        end else if (mFresh) begin
            mFresh = 0;
            mWaiting = 1;
        end else if (mWaiting) begin
            if (imemAck) begin
                mInstr = imemRdata;
                mPc = mNext;
                mWaiting = 0;
                mHolding = 1;
            end
        end else if (mHolding && !stall) begin
            mCount = mCount + 1;
            mHolding = 0;
            if (pcSrc && pcTarget[1:0] != 2'b00) begin
                mMis = 1;
                mDead = 1;
            end else begin
                mNext = pcSrc ? pcTarget : mNext + 4;
                mWaiting = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkEn && rst_n) begin
            check("imemReq", {31'd0, imemReq}, {31'd0, mWaiting});
            check("imemAddr", imemAddr, mNext);
            check("instrValid", {31'd0, instrValid}, {31'd0, mHolding});
            check("instr", instr, mInstr);
            check("op", {25'd0, op}, {25'd0, mInstr[6:0]});
            check("pc", pc, mPc);
            check("pcPlus4", pcPlus4, mPc + 32'd4);
            check("misaligned", {31'd0, misaligned}, {31'd0, mMis});
            check("fetchCount", fetchCount, mCount);
        end
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_req"}, {31'd0, imemReq}, 32'd0);
        check({tag, "_addr"}, imemAddr, 32'd0);
        check({tag, "_instr"}, instr, 32'h0000_0013);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_pc4"}, pcPlus4, 32'd4);
        check({tag, "_valid"}, {31'd0, instrValid}, 32'd0);
        check({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
        check({tag, "_cnt"}, fetchCount, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        chkEn = 1'b1;
        tick(); tick();
        checkResetValues("rst0");

        // Zero-latency memory, first fetch.
        rst_n = 1'b1;
        imemAck = 1'b1;
        imemRdata = 32'h0050_0093;
        tick();
        check("boot_req", {31'd0, imemReq}, 32'd1);
        check("boot_addr", imemAddr, 32'd0);
        tick();
        check("first_valid", {31'd0, instrValid}, 32'd1);
        check("first_instr", instr, 32'h0050_0093);
        check("first_op", {25'd0, op}, 32'h13);
        check("first_pc4", pcPlus4, 32'd4);

        // Redirect to 0x40.
        stall = 1'b0; pcSrc = 1'b1; pcTarget = 32'h40; imemAck = 1'b0;
        tick();
        check("redir_addr", imemAddr, 32'h40);
        stall = 1'b1; pcSrc = 1'b0; imemAck = 1'b1; imemRdata = 32'h0000_006F;
        tick();
        check("redir_pc", pc, 32'h40);
        check("redir_pc4", pcPlus4, 32'h44);

        // Misaligned redirect halts.
        stall = 1'b0; pcSrc = 1'b1; pcTarget = 32'h42;
        tick();
        stall = 1'b1; pcSrc = 1'b0;
        repeat (20) begin
            imemAck = 1'($urandom);
            tick();
        end
        check("halt_mis", {31'd0, misaligned}, 32'd1);
        check("halt_req", {31'd0, imemReq}, 32'd0);
        check("halt_valid", {31'd0, instrValid}, 32'd0);
        check("halt_cnt", fetchCount, 32'd2);
        check("halt_addr", imemAddr, 32'h40);

        // Asynchronous reset between edges, late ack in BOOT ignored.
        #2 rst_n = 1'b0;
        #1 checkResetValues("arst");
        tick();
        rst_n = 1'b1; imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
        tick();
        check("postrst_valid", {31'd0, instrValid}, 32'd0);
        check("postrst_addr", imemAddr, 32'd0);
        check("postrst_instr", instr, 32'h0000_0013);

        // Randomized episodes.
        for (int ep = 0; ep < 20; ep++) begin
            for (int cyc = 0; cyc < 150; cyc++) begin
                imemAck = ($urandom_range(0, 2) == 0);
                imemRdata = memWord(imemAddr);
                stall = ($urandom_range(0, 3) == 0);
                pcSrc = ($urandom_range(0, 4) == 0);
                r = $urandom;
                case ($urandom_range(0, 19))
                    0: pcTarget = r | 32'd1;
                    1: pcTarget = 32'hFFFF_FFF8;
                    2: pcTarget = 32'hFFFF_FFFC;
                    default: pcTarget = r & 32'hFFFF_FFFC;
                endcase
                tick();
            end
            #($urandom_range(0, 3)) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        tick();
        chkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
